// File: rtl/washer_pkg.sv
// Shared definitions between the washing controller and its state timer:
// duration codes, code-to-minutes table and timer state encoding.
package washer_pkg;

    localparam logic [2:0] CODE_IDLE  = 3'd0;
    localparam logic [2:0] CODE_FILL  = 3'd1;
    localparam logic [2:0] CODE_WASH  = 3'd2;
    localparam logic [2:0] CODE_RINSE = 3'd3;
    localparam logic [2:0] CODE_SPIN  = 3'd4;
    localparam logic [2:0] CODE_DONE  = 3'd5;

    localparam logic [2:0] MIN_FILL  = 3'd2;
    localparam logic [2:0] MIN_WASH  = 3'd5;
    localparam logic [2:0] MIN_RINSE = 3'd2;
    localparam logic [2:0] MIN_SPIN  = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_FIRE = 2'd3
    } timer_state_e;

    // Unlisted and terminal codes map to zero minutes, which disarms the timer.
    function automatic logic [2:0] code_minutes(input logic [2:0] code);
        logic [2:0] minutes;
        case (code)
            CODE_IDLE:  minutes = 3'd0;
            CODE_FILL:  minutes = MIN_FILL;
            CODE_WASH:  minutes = MIN_WASH;
            CODE_RINSE: minutes = MIN_RINSE;
            CODE_SPIN:  minutes = MIN_SPIN;
            CODE_DONE:  minutes = 3'd0;
            default:    minutes = 3'd0;
        endcase
        return minutes;
    endfunction

endpackage

// File: rtl/minute_tick_gen.sv
// Minute prescaler: counts enabled cycles and emits a one-cycle tick on the
// cycle the count reaches period-1, wrapping back to zero.
module minute_tick_gen #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] count_r;
    logic             at_end_s;

    // >= keeps the counter from running away should period ever shrink under it.
    assign at_end_s = (count_r >= (period - CNT_W'(1)));
    assign tick     = enable & at_end_s;

    // Prescaler count: clear wins, then wrap on tick, else advance while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (tick) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/state_timer.sv
// Duration timer for the washing controller: loads a minute count whenever the
// state code changes and pulses Trigger_clk_FSM when that duration has elapsed.
module state_timer #(
    parameter int unsigned BASE_TICKS = 60000000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [1:0] Freq_sel,
    input  logic [2:0] Duration_clk_FSM,
    input  logic       Pause,
    output logic       Trigger_clk_FSM,
    output logic       Timer_busy,
    output logic [2:0] Minutes_left
);

    import washer_pkg::*;

    timer_state_e     state_r;
    timer_state_e     state_s;
    logic [2:0]       code_r;
    logic [1:0]       freq_r;
    logic [2:0]       minutes_r;
    logic [2:0]       minutes_s;
    logic             trigger_r;
    logic             trigger_s;
    logic             busy_r;
    logic             busy_s;
    logic             load_s;
    logic [2:0]       load_minutes_s;
    logic             enable_s;
    logic             tick_s;
    logic [CNT_W-1:0] period_s;

    assign load_s         = (Duration_clk_FSM != code_r);
    assign load_minutes_s = code_minutes(Duration_clk_FSM);
    assign period_s       = CNT_W'(BASE_TICKS) << freq_r;

    // Counting also runs on the HOLD->RUN edge so a pause costs exactly its own length.
    assign enable_s = !load_s && !Pause && ((state_r == ST_RUN) || (state_r == ST_HOLD));

    minute_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .clear  (load_s),
        .enable (enable_s),
        .period (period_s),
        .tick   (tick_s)
    );

    // Next-state and minute counter; a load overrides pause and expiry.
    always_comb begin
        state_s   = state_r;
        minutes_s = minutes_r;
        if (load_s) begin
            minutes_s = load_minutes_s;
            if (load_minutes_s != 3'd0) begin
                state_s = ST_RUN;
            end else begin
                state_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s   = ST_IDLE;
                    minutes_s = 3'd0;
                end
                ST_RUN, ST_HOLD: begin
                    if (Pause) begin
                        state_s = ST_HOLD;
                    end else if (tick_s) begin
                        minutes_s = minutes_r - 3'd1;
                        if (minutes_r == 3'd1) begin
                            state_s = ST_FIRE;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_FIRE: begin
                    state_s   = ST_IDLE;
                    minutes_s = 3'd0;
                end
                default: begin
                    state_s   = ST_IDLE;
                    minutes_s = 3'd0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs align with it.
    always_comb begin
        trigger_s = (state_s == ST_FIRE);
        busy_s    = (state_s == ST_RUN) || (state_s == ST_HOLD);
    end

    // State, code copy, latched rate and registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r   <= ST_IDLE;
            code_r    <= 3'd0;
            freq_r    <= 2'd0;
            minutes_r <= 3'd0;
            trigger_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            code_r    <= Duration_clk_FSM;
            minutes_r <= minutes_s;
            trigger_r <= trigger_s;
            busy_r    <= busy_s;
            if (load_s) begin
                freq_r <= Freq_sel;
            end else begin
                freq_r <= freq_r;
            end
        end
    end

    assign Trigger_clk_FSM = trigger_r;
    assign Timer_busy      = busy_r;
    assign Minutes_left    = minutes_r;

endmodule

// File: tb/tb_state_timer.sv
// Self-checking bench for state_timer: directed scenarios plus random traffic,
// all compared cycle by cycle against a remaining-cycles reference model.
module tb_state_timer;

    localparam int BT = 4;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [1:0] Freq_sel;
    logic [2:0] Duration_clk_FSM;
    logic       Pause;
    logic       Trigger_clk_FSM;
    logic       Timer_busy;
    logic [2:0] Minutes_left;

    int checks = 0;
    int errors = 0;

    // Reference model: a load arms D*T remaining cycles, each unpaused edge burns one.
    int minutes_tbl [8] = '{0, 2, 5, 2, 1, 0, 0, 0};
    int m_prev_code;
    int m_active;
    int m_remaining;
    int m_period;
    int m_trig;

    state_timer #(
        .BASE_TICKS (BT),
        .CNT_W      (32)
    ) dut (
        .Clk              (Clk),
        .Rst_n            (Rst_n),
        .Freq_sel         (Freq_sel),
        .Duration_clk_FSM (Duration_clk_FSM),
        .Pause            (Pause),
        .Trigger_clk_FSM  (Trigger_clk_FSM),
        .Timer_busy       (Timer_busy),
        .Minutes_left     (Minutes_left)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_prev_code = 0;
        m_active    = 0;
        m_remaining = 0;
        m_period    = BT;
        m_trig      = 0;
    endtask

    task automatic model_edge();
        m_trig = 0;
        if (int'(Duration_clk_FSM) != m_prev_code) begin
            m_prev_code = int'(Duration_clk_FSM);
            if (minutes_tbl[m_prev_code] > 0) begin
                m_active    = 1;
                m_period    = BT << Freq_sel;
                m_remaining = minutes_tbl[m_prev_code] * m_period;
            end else begin
                m_active    = 0;
                m_remaining = 0;
            end
        end else if (m_active != 0 && !Pause) begin
            m_remaining = m_remaining - 1;
            if (m_remaining == 0) begin
                m_active = 0;
                m_trig   = 1;
            end
        end
    endtask

    function automatic int exp_minutes();
        if (m_active == 0) return 0;
        return (m_remaining + m_period - 1) / m_period;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check("trigger", {31'd0, Trigger_clk_FSM}, m_trig);
        check("busy", {31'd0, Timer_busy}, m_active);
        check("minutes", {29'd0, Minutes_left}, exp_minutes());
    endtask

    task automatic wait_trigger(input int limit, output int n);
        bit fired;
        fired = 1'b0;
        n = 0;
        while (!fired && n < limit) begin
            step();
            n++;
            if (Trigger_clk_FSM === 1'b1) fired = 1'b1;
        end
    endtask

    initial begin
        int n;
        int total;
        int trig_seen;

        Rst_n = 1'b0;
        Freq_sel = 2'd0;
        Duration_clk_FSM = 3'd0;
        Pause = 1'b0;
        model_reset();
        #12;
        check("rst_trigger", {31'd0, Trigger_clk_FSM}, 32'd0);
        check("rst_busy", {31'd0, Timer_busy}, 32'd0);
        check("rst_minutes", {29'd0, Minutes_left}, 32'd0);
        Rst_n = 1'b1;
        repeat (2) step();

        // Fill at 1x: two minutes of four cycles each
        Duration_clk_FSM = 3'd1;
        step();
        check("fill_load_min", {29'd0, Minutes_left}, 32'd2);
        check("fill_load_busy", {31'd0, Timer_busy}, 32'd1);
        wait_trigger(40, n);
        check("fill_latency", n, 32'd8);
        step();
        check("fill_after_busy", {31'd0, Timer_busy}, 32'd0);
        check("fill_after_trig", {31'd0, Trigger_clk_FSM}, 32'd0);

        // Wash at 8x; rate change mid-run must be ignored
        Freq_sel = 2'd3;
        Duration_clk_FSM = 3'd2;
        step();
        Freq_sel = 2'd0;
        wait_trigger(200, n);
        check("wash_latency", n, 32'd160);

        // Spin with a ten-cycle pause
        Duration_clk_FSM = 3'd0;
        step();
        Duration_clk_FSM = 3'd4;
        step();
        repeat (2) step();
        Pause = 1'b1;
        repeat (10) begin
            step();
            check("pause_frozen_min", {29'd0, Minutes_left}, 32'd1);
        end
        Pause = 1'b0;
        wait_trigger(40, n);
        total = 2 + 10 + n;
        check("spin_pause_latency", total, 32'd14);

        // Code change on the expiry cycle restarts instead of firing
        Duration_clk_FSM = 3'd0;
        step();
        Duration_clk_FSM = 3'd1;
        step();
        repeat (7) step();
        Duration_clk_FSM = 3'd3;
        step();
        check("collide_no_trig", {31'd0, Trigger_clk_FSM}, 32'd0);
        check("collide_min", {29'd0, Minutes_left}, 32'd2);
        wait_trigger(40, n);
        check("collide_latency", n, 32'd8);

        // Zero-minute codes never arm
        trig_seen = 0;
        Duration_clk_FSM = 3'd5;
        repeat (20) begin
            step();
            if (Trigger_clk_FSM === 1'b1) trig_seen++;
        end
        Duration_clk_FSM = 3'd0;
        repeat (20) begin
            step();
            if (Trigger_clk_FSM === 1'b1) trig_seen++;
        end
        check("zero_code_triggers", trig_seen, 32'd0);
        check("zero_code_busy", {31'd0, Timer_busy}, 32'd0);

        // Reset in the middle of a wash, then reload on release
        Duration_clk_FSM = 3'd2;
        repeat (6) step();
        #3;
        Rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_trigger", {31'd0, Trigger_clk_FSM}, 32'd0);
        check("midrst_busy", {31'd0, Timer_busy}, 32'd0);
        check("midrst_minutes", {29'd0, Minutes_left}, 32'd0);
        #2;
        Rst_n = 1'b1;
        step();
        check("reload_busy", {31'd0, Timer_busy}, 32'd1);
        check("reload_min", {29'd0, Minutes_left}, 32'd5);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) Duration_clk_FSM = 3'($urandom_range(0, 7));
            Pause = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) Freq_sel = 2'($urandom_range(0, 1));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
